// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, data width, reset vector.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_byte_swap.sv
// Byte-reversal of a fetched word for a little-endian instruction bus.
// Present only when FETCH_BYTE_SWAP_EN is defined.
`ifdef FETCH_BYTE_SWAP_EN
module fetch_byte_swap
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out
);

  assign data_out = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit sharing one read bus with the data side (data has priority).
// Optional FETCH_BYTE_SWAP_EN byte-reverses returned words for a little-endian bus.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [cpu_pkg::XLEN-1:0]  pc_address,
  input  logic                      pc_halt,
  input  logic                      flush,
  input  logic                      data_request,
  input  logic                      decode_stall,
  input  logic                      mem_waitrequest,
  input  logic [cpu_pkg::XLEN-1:0]  mem_readdata,
  output logic [cpu_pkg::XLEN-1:0]  mem_address,
  output logic                      mem_read,
  output logic                      memory_hazard,
  output logic [cpu_pkg::XLEN-1:0]  instruction,
  output logic [cpu_pkg::XLEN-1:0]  instr_address,
  output logic                      instr_valid,
  output logic                      fetch_error
);
  import cpu_pkg::*;

  fetch_state_t    state_q, state_d;
  logic            mem_read_q, mem_read_d;
  logic [XLEN-1:0] mem_address_q, mem_address_d;
  logic [XLEN-1:0] instruction_q, instruction_d;
  logic [XLEN-1:0] instr_address_q, instr_address_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_error_q, fetch_error_d;
  logic            flush_pend_q, flush_pend_d;
  logic            halt_pend_q, halt_pend_d;
  logic            memory_hazard_c;
  logic [XLEN-1:0] rd_word;

`ifdef FETCH_BYTE_SWAP_EN
  fetch_byte_swap u_swap (
    .data_in  (mem_readdata),
    .data_out (rd_word)
  );
`else
  assign rd_word = mem_readdata;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    mem_read_d      = mem_read_q;
    mem_address_d   = mem_address_q;
    instruction_d   = instruction_q;
    instr_address_d = instr_address_q;
    instr_valid_d   = 1'b0;
    fetch_error_d   = fetch_error_q;
    flush_pend_d    = flush_pend_q;
    halt_pend_d     = halt_pend_q;
    memory_hazard_c = 1'b0;
    case (state_q)
      IDLE: begin
        mem_read_d = 1'b0;
        if (pc_halt) begin
          state_d = HALTED;
        end else if (flush) begin
          state_d = IDLE;
        end else if (pc_address[1:0] != 2'b00) begin
          fetch_error_d = 1'b1;
          state_d       = HALTED;
        end else if (data_request) begin
          memory_hazard_c = 1'b1;
        end else begin
          mem_address_d = {pc_address[XLEN-1:2], 2'b00};
          mem_read_d    = 1'b1;
          flush_pend_d  = 1'b0;
          halt_pend_d   = 1'b0;
          state_d       = READ;
        end
      end
      READ: begin
        // A started bus read always runs to completion; flush/halt only mark the result.
        if (mem_waitrequest) begin
          memory_hazard_c = 1'b1;
          flush_pend_d    = flush_pend_q | flush;
          halt_pend_d     = halt_pend_q | pc_halt;
        end else begin
          mem_read_d   = 1'b0;
          flush_pend_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (halt_pend_q || pc_halt) begin
            state_d = HALTED;
          end else if (flush_pend_q || flush) begin
            state_d = IDLE;
          end else begin
            instruction_d   = rd_word;
            instr_address_d = mem_address_q;
            instr_valid_d   = 1'b1;
            state_d         = decode_stall ? HOLD : IDLE;
          end
        end
      end
      HOLD: begin
        memory_hazard_c = 1'b1;
        if (flush || !decode_stall) begin
          state_d = IDLE;
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      HALTED: begin
        mem_read_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_read_q      <= 1'b0;
      mem_address_q   <= '0;
      instruction_q   <= '0;
      instr_address_q <= RESET_VECTOR;
      instr_valid_q   <= 1'b0;
      fetch_error_q   <= 1'b0;
      flush_pend_q    <= 1'b0;
      halt_pend_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_address_q   <= mem_address_d;
      instruction_q   <= instruction_d;
      instr_address_q <= instr_address_d;
      instr_valid_q   <= instr_valid_d;
      fetch_error_q   <= fetch_error_d;
      flush_pend_q    <= flush_pend_d;
      halt_pend_q     <= halt_pend_d;
    end
  end

  // Hazard must act in the current cycle, so it is the one combinational output.
  assign memory_hazard = memory_hazard_c & ~reset;
  assign mem_read      = mem_read_q;
  assign mem_address   = mem_address_q;
  assign instruction   = instruction_q;
  assign instr_address = instr_address_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_error   = fetch_error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-transaction timelines derived from wait/stall counts.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        pc_halt, flush, data_request, decode_stall, mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] mem_address;
  logic        mem_read, memory_hazard;
  logic [31:0] instruction, instr_address;
  logic        instr_valid, fetch_error;

  int vectors = 0;
  int miscompares = 0;

  logic        exp_valid_next = 1'b0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_iaddr = 32'h0;

  localparam logic [31:0] RV = 32'hBFC00000;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc_address      (pc_address),
    .pc_halt         (pc_halt),
    .flush           (flush),
    .data_request    (data_request),
    .decode_stall    (decode_stall),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .memory_hazard   (memory_hazard),
    .instruction     (instruction),
    .instr_address   (instr_address),
    .instr_valid     (instr_valid),
    .fetch_error     (fetch_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input logic [31:0] d);
`ifdef FETCH_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] rand_aligned();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_halt = 1'b0; flush = 1'b0; data_request = 1'b0;
    decode_stall = 1'b0; mem_waitrequest = 1'b0;
  endtask

  // Checks the pulse/hold left by the previous transaction, observed in the current IDLE cycle.
  task automatic check_prev(input string tag);
    vectors++;
    if (instr_valid !== exp_valid_next) begin
      miscompares++;
      $display("FAIL %s prev_valid: got %b want %b", tag, instr_valid, exp_valid_next);
    end
    if (exp_valid_next) begin
      vectors++;
      if (instruction !== exp_instr || instr_address !== exp_iaddr) begin
        miscompares++;
        $display("FAIL %s prev_word: got %h@%h want %h@%h", tag, instruction, instr_address, exp_instr, exp_iaddr);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_valid_next = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_address = 32'h0; mem_readdata = $urandom;
    reset = 1'b1;
    tick(); tick();
    data_request = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || mem_address !== 32'h0 || memory_hazard !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: rd=%b addr=%h hz=%b want 0/0/0", mem_read, mem_address, memory_hazard);
    end
    vectors++;
    if (instruction !== 32'h0 || instr_valid !== 1'b0 || fetch_error !== 1'b0 || instr_address !== RV) begin
      miscompares++;
      $display("FAIL reset_out: ins=%h v=%b err=%b ia=%h want 0/0/0/%h", instruction, instr_valid, fetch_error, instr_address, RV);
    end
    data_request = 1'b0;
    reset = 1'b0;
    exp_valid_next = 1'b0;
  endtask

  // One fetch from IDLE: w wait cycles, s hold cycles after return, flush on hold cycle fl (0 = none).
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int w, input int s, input int fl);
    logic [31:0] expi;
    expi = model_word(d);
    idle_inputs();
    pc_address = a; mem_waitrequest = (w > 0); mem_readdata = $urandom;
    #1;
    check_prev("fetch");
    vectors++;
    if (mem_read !== 1'b0 || memory_hazard !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_idle: rd=%b hz=%b want 0/0", mem_read, memory_hazard);
    end
    tick();
    for (int i = 0; i < w; i++) begin
      mem_waitrequest = 1'b1; mem_readdata = $urandom; pc_address = $urandom;
      #1;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== a || memory_hazard !== 1'b1 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_wait: rd=%b addr=%h hz=%b v=%b want 1/%h/1/0", mem_read, mem_address, memory_hazard, instr_valid, a);
      end
      tick();
    end
    mem_waitrequest = 1'b0; mem_readdata = d; decode_stall = (s > 0);
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== a || memory_hazard !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_done: rd=%b addr=%h hz=%b want 1/%h/0", mem_read, mem_address, memory_hazard, a);
    end
    tick();
    mem_readdata = $urandom;
    exp_instr = expi; exp_iaddr = a;
    for (int j = 1; j <= s; j++) begin
      decode_stall = (j < s); flush = (j == fl);
      #1;
      vectors++;
      if (instr_valid !== 1'b1 || instruction !== expi || instr_address !== a || memory_hazard !== 1'b1 || mem_read !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_hold%0d: v=%b ins=%h ia=%h hz=%b rd=%b want 1/%h/%h/1/0", j, instr_valid, instruction, instr_address, memory_hazard, mem_read, expi, a);
      end
      tick();
      if (j == fl) break;
    end
    idle_inputs();
    exp_valid_next = (s == 0);
  endtask

  task automatic test_random_fetch();
    for (int k = 0; k < 24; k++) begin
      int s;
      s = $urandom_range(0, 3);
      do_fetch(rand_aligned(), $urandom, $urandom_range(0, 4), s, (s > 1) ? $urandom_range(0, s - 1) : 0);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a1;
    int w;
    a1 = rand_aligned();
    w = $urandom_range(1, 3);
    idle_inputs();
    pc_address = a1; mem_waitrequest = 1'b1;
    #1;
    check_prev("flush");
    tick();
    for (int i = 0; i < w; i++) begin
      flush = (i == 0); pc_address = $urandom;
      #1;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== a1) begin
        miscompares++;
        $display("FAIL flush_read: rd=%b addr=%h want 1/%h", mem_read, mem_address, a1);
      end
      tick();
    end
    flush = 1'b0; mem_waitrequest = 1'b0; mem_readdata = $urandom;
    tick();
    exp_valid_next = 1'b0;
    do_fetch(rand_aligned(), $urandom, 0, 0, 0);
  endtask

  task automatic test_data_request();
    int r;
    r = $urandom_range(1, 4);
    for (int i = 0; i < r; i++) begin
      idle_inputs();
      data_request = 1'b1; pc_address = rand_aligned();
      #1;
      if (i == 0) check_prev("dreq");
      vectors++;
      if (mem_read !== 1'b0 || memory_hazard !== 1'b1) begin
        miscompares++;
        $display("FAIL dreq_block: rd=%b hz=%b want 0/1", mem_read, memory_hazard);
      end
      tick();
      exp_valid_next = 1'b0;
    end
    do_fetch(rand_aligned(), $urandom, $urandom_range(0, 2), 0, 0);
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    pc_address = rand_aligned(); mem_waitrequest = 1'b1;
    #1;
    check_prev("rstrd");
    tick();
    reset = 1'b1; mem_waitrequest = 1'b0; mem_readdata = $urandom;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_address !== RV || mem_address !== 32'h0) begin
      miscompares++;
      $display("FAIL rstrd_out: rd=%b v=%b ins=%h ia=%h addr=%h want 0/0/0/%h/0", mem_read, instr_valid, instruction, instr_address, mem_address, RV);
    end
    exp_valid_next = 1'b0;
    do_fetch(rand_aligned(), $urandom, 1, 0, 0);
  endtask

  // Idle in HALTED for n cycles with an otherwise fetchable input pattern.
  task automatic expect_halted(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      pc_address = rand_aligned(); data_request = $urandom_range(0, 1);
      #1;
      vectors++;
      if (mem_read !== 1'b0 || instr_valid !== 1'b0 || memory_hazard !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_halted: rd=%b v=%b hz=%b want 0/0/0", tag, mem_read, instr_valid, memory_hazard);
      end
      tick();
    end
  endtask

  task automatic test_halt_in_read();
    idle_inputs();
    pc_address = rand_aligned(); mem_waitrequest = 1'b1;
    #1;
    check_prev("haltrd");
    tick();
    pc_halt = 1'b1;
    tick();
    pc_halt = 1'b0; mem_waitrequest = 1'b0; mem_readdata = $urandom;
    #1;
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL haltrd_complete: rd=%b want 1", mem_read);
    end
    tick();
    expect_halted(4, "haltrd");
    do_reset();
  endtask

  task automatic test_halt_idle_flush();
    idle_inputs();
    pc_address = rand_aligned(); pc_halt = 1'b1; flush = 1'b1;
    tick();
    expect_halted(4, "haltfl");
    do_reset();
    do_fetch(rand_aligned(), $urandom, 0, 0, 0);
  endtask

  task automatic test_misaligned();
    idle_inputs();
    pc_address = 32'hBFC00002;
    #1;
    check_prev("misal");
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      pc_address = rand_aligned();
      #1;
      vectors++;
      if (fetch_error !== 1'b1 || mem_read !== 1'b0 || memory_hazard !== 1'b0) begin
        miscompares++;
        $display("FAIL misal_halt: err=%b rd=%b hz=%b want 1/0/0", fetch_error, mem_read, memory_hazard);
      end
      tick();
    end
    do_reset();
    #1;
    vectors++;
    if (fetch_error !== 1'b0) begin
      miscompares++;
      $display("FAIL misal_clear: err=%b want 0", fetch_error);
    end
  endtask

  initial begin
    test_reset();
    do_fetch(32'hBFC00000, 32'h12345678, 0, 0, 0);
    do_fetch(rand_aligned(), $urandom, 3, 0, 0);
    do_fetch(rand_aligned(), $urandom, 0, 2, 0);
    do_fetch(rand_aligned(), $urandom, 1, 3, 1);
    test_random_fetch();
    test_flush();
    test_data_request();
    test_reset_mid_read();
    test_halt_in_read();
    test_halt_idle_flush();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000: instr_address value after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port pc_address, input, 32: fetch address from PC.
REQ-005 SHALL have port pc_halt, input, 1: PC has halted; stop fetching.
REQ-006 SHALL have port flush, input, 1: branch/jump redirect; discard in-flight and held instruction.
REQ-007 SHALL have port data_request, input, 1: execute stage owns shared bus this cycle; data side has priority.
REQ-008 SHALL have port decode_stall, input, 1: downstream cannot accept instruction.
REQ-009 SHALL have port mem_waitrequest, input, 1: bus not ready; hold request.
REQ-010 SHALL have port mem_readdata, input, 32: read data, valid in READ when mem_waitrequest=0.
REQ-011 SHALL have port mem_address, output, 32: word-aligned read address.
REQ-012 SHALL have port mem_read, output, 1: read strobe.
REQ-013 SHALL have port memory_hazard, output, 1: PC must not advance this cycle.
REQ-014 SHALL have port instruction, output, 32: fetched instruction word.
REQ-015 SHALL have port instr_address, output, 32: address of instruction.
REQ-016 SHALL have port instr_valid, output, 1: instruction/instr_address valid.
REQ-017 SHALL have port fetch_error, output, 1: sticky misaligned-fetch flag.

Function
REQ-018 SHALL implement states IDLE, READ, HOLD, HALTED.
REQ-019 IDLE: pc_halt -> HALTED; else pc_address[1:0]!=0 -> set fetch_error, HALTED; else data_request -> stay IDLE, memory_hazard=1; else latch pc_address, -> READ.
REQ-020 READ: mem_read=1, mem_address=latched address; mem_waitrequest=1 -> stay, memory_hazard=1.
REQ-021 READ, mem_waitrequest=0: capture mem_readdata and address, instr_valid=1 next cycle; -> HOLD if decode_stall else IDLE.
REQ-022 Latency: pc_address sampled cycle N, mem_read high N+1, zero-wait instr_valid high N+2.
REQ-023 HOLD: outputs frozen, memory_hazard=1; leave to IDLE first cycle decode_stall=0.
REQ-024 instr_valid SHALL pulse one cycle per accepted word unless held in HOLD.
REQ-025 flush in READ: bus read SHALL complete (no abort); returned data discarded, instr_valid stays 0.
REQ-026 flush in IDLE/HOLD: instr_valid cleared next cycle, -> IDLE.
REQ-027 pc_halt and flush same cycle: pc_halt wins; pc_halt in READ takes effect after read completes.
REQ-028 HALTED: mem_read=0, instr_valid=0, memory_hazard=0; exit only by reset.
REQ-029 mem_read SHALL never assert while data_request=1 at the IDLE->READ decision.

Reset
REQ-030 Reset SHALL force IDLE, mem_read=0, mem_address=0, memory_hazard=0, instruction=0, instr_valid=0, fetch_error=0, instr_address=RESET_VECTOR.
REQ-031 Reset mid-READ SHALL drop mem_read next edge and discard pending data.

Configuration
REQ-032 Macro FETCH_BYTE_SWAP_EN defined: instruction = byte-reversed mem_readdata ({[7:0],[15:8],[23:16],[31:24]}), for little-endian bus.
REQ-033 Macro undefined: instruction = mem_readdata unchanged; no other behaviour differs.

Structure
REQ-034 Package cpu_pkg SHALL hold fetch_state_t enum and RESET_VECTOR constant 32'hBFC00000.
REQ-035 Byte reversal SHALL be sub-module fetch_byte_swap, instantiated only under FETCH_BYTE_SWAP_EN.

Verification
REQ-036 Reset, pc_address=BFC00000, waitrequest=0 -> mem_read cycle 1, instr_valid cycle 2 with instr_address=BFC00000.
REQ-037 waitrequest=1 for 3 cycles -> mem_read held 4 cycles, memory_hazard=1 for 3, one instr_valid pulse.
REQ-038 decode_stall=1 2 cycles after return -> instruction held stable in HOLD, memory_hazard=1, released when stall drops.
REQ-039 flush during stalled READ -> read completes, instr_valid stays 0, next fetch uses new pc_address.
REQ-040 pc_address=BFC00002 -> fetch_error=1, HALTED, mem_read never asserted; data_request=1 in IDLE -> no mem_read, memory_hazard=1.
REQ-041 mem_readdata=12345678 -> instruction=78563412 with FETCH_BYTE_SWAP_EN, 12345678 without.
